// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between two requesters.
// Optional watchdog on the WAIT state enabled with ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [6:0]        addr0,
  input  logic [6:0]        addr1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_abort,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_ack_err,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   sel;         // index of the requester holding the grant
  logic   last_grant;
  logic   win;
  logic   timeout_hit;

  // On a tie the requester that was not served last wins.
  always_comb begin
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    m_start   = 1'b0;
    m_abort   = 1'b0;
    done      = 2'b00;
    case (state)
      IDLE:   if (req != 2'b00) state_nxt = LAUNCH;
      LAUNCH: if (!m_busy) begin
        m_start   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (m_done) state_nxt = RESP;
        else if (timeout_hit) begin
          m_abort   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        done      = sel ? 2'b10 : 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      gnt        <= 2'b00;
      m_addr     <= '0;
      m_rw       <= 1'b0;
      m_wdata    <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req != 2'b00) begin
          sel     <= win;
          gnt     <= win ? 2'b10 : 2'b01;
          m_addr  <= win ? addr1  : addr0;
          m_rw    <= win ? rw1    : rw0;
          m_wdata <= win ? wdata1 : wdata0;
        end
        WAIT: begin
          if (m_done) begin
            rdata <= m_rdata;
            err   <= m_ack_err;
          end else if (timeout_hit) begin
            rdata <= '0;
            err   <= 1'b1;
          end
        end
        RESP: begin
          last_grant <= sel;
          gnt        <= 2'b00;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  logic [CW-1:0] cnt;

  // cnt equals the number of WAIT cycles already elapsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt <= '0;
    else if (state == LAUNCH && !m_busy)    cnt <= '0;
    else if (state == WAIT)                 cnt <= cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && (cnt == CW'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed testbench for i2c_master_arbiter; define ARB_TIMEOUT_EN to add the watchdog test.
module tb_i2c_master_arbiter;
  localparam int DW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = '0;
  logic [6:0]    addr0 = '0, addr1 = '0;
  logic          rw0 = 1'b0, rw1 = 1'b0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]    gnt, done;
  logic [DW-1:0] rdata, m_wdata;
  logic          err, m_start, m_rw, m_abort;
  logic [6:0]    m_addr;
  logic          m_busy = 1'b0, m_done = 1'b0, m_ack_err = 1'b0;
  logic [DW-1:0] m_rdata = 16'hdead;

  int checks = 0;
  int failures = 0;

  i2c_master_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .rw0(rw0), .rw1(rw1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Plays the master side of one transaction; returns what the requesters saw.
  task automatic serve(input logic [DW-1:0] mrd, input logic mack,
                       output logic [1:0] g, output logic [6:0] a, output logic r,
                       output logic [1:0] d, output logic [DW-1:0] rd, output logic e);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!m_start && n < 20);
    checks++;
    if (m_start !== 1'b1) begin
      failures++;
      $display("FAIL serve_start: m_start=%0b after %0d cycles, required 1", m_start, n);
    end
    g = gnt; a = m_addr; r = m_rw;
    @(negedge clk);
    m_done = 1'b1; m_rdata = mrd; m_ack_err = mack;
    @(negedge clk);
    m_done = 1'b0; m_rdata = 16'hdead; m_ack_err = 1'b0;
    #1;
    d = done; rd = rdata; e = err;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (gnt !== 2'b00)   begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (done !== 2'b00)  begin failures++; $display("FAIL reset_done: got %b want 00", done); end
    checks++; if (m_start !== 1'b0 || m_abort !== 1'b0) begin failures++; $display("FAIL reset_strobes: start=%b abort=%b want 0 0", m_start, m_abort); end
    checks++; if (rdata !== '0 || err !== 1'b0) begin failures++; $display("FAIL reset_resp: rdata=%h err=%b want 0000 0", rdata, err); end
    checks++; if (m_addr !== '0 || m_wdata !== '0 || m_rw !== 1'b0) begin failures++; $display("FAIL reset_cmd: addr=%h wdata=%h rw=%b want 0", m_addr, m_wdata, m_rw); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 2'b01; addr0 = 7'h50; rw0 = 1'b0; wdata0 = 16'hA5C3; m_busy = 1'b0;
    @(negedge clk); #1;
    checks++; if (gnt !== 2'b01 || m_start !== 1'b1) begin failures++; $display("FAIL single_launch: gnt=%b start=%b want 01 1", gnt, m_start); end
    checks++; if (m_addr !== 7'h50 || m_wdata !== 16'hA5C3 || m_rw !== 1'b0) begin failures++; $display("FAIL single_cmd: addr=%h wdata=%h rw=%b want 50 a5c3 0", m_addr, m_wdata, m_rw); end
    @(negedge clk); #1;
    checks++; if (m_start !== 1'b0 || gnt !== 2'b01 || done !== 2'b00) begin failures++; $display("FAIL single_wait: start=%b gnt=%b done=%b want 0 01 00", m_start, gnt, done); end
    m_done = 1'b1; m_ack_err = 1'b0; m_rdata = 16'h0000;
    @(negedge clk);
    m_done = 1'b0; m_rdata = 16'hdead; req = 2'b00; #1;
    checks++; if (done !== 2'b01 || err !== 1'b0) begin failures++; $display("FAIL single_done: done=%b err=%b want 01 0", done, err); end
    @(negedge clk); #1;
    checks++; if (done !== 2'b00 || gnt !== 2'b00) begin failures++; $display("FAIL single_release: done=%b gnt=%b want 00 00", done, gnt); end
  endtask

  task automatic test_tie();
    logic [1:0] g, d, exp;
    logic [6:0] a;
    logic r, e;
    logic [DW-1:0] rd;
    do_reset();
    req = 2'b11; addr0 = 7'h11; addr1 = 7'h22;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      serve(16'h0100 + 16'(i), 1'b0, g, a, r, d, rd, e);
      checks++; if (g !== exp) begin failures++; $display("FAIL tie_gnt%0d: got %b want %b", i, g, exp); end
      checks++; if (d !== exp || a !== (exp[1] ? 7'h22 : 7'h11)) begin failures++; $display("FAIL tie_done%0d: done=%b addr=%h want %b", i, d, a, exp); end
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_read_return();
    logic [1:0] g, d;
    logic [6:0] a;
    logic r, e;
    logic [DW-1:0] rd;
    @(negedge clk);
    req = 2'b10; addr1 = 7'h2A; rw1 = 1'b1; wdata1 = 16'h0F0F;
    serve(16'h1234, 1'b1, g, a, r, d, rd, e);
    req = 2'b00;
    checks++; if (g !== 2'b10 || a !== 7'h2A || r !== 1'b1) begin failures++; $display("FAIL read_cmd: gnt=%b addr=%h rw=%b want 10 2a 1", g, a, r); end
    checks++; if (d !== 2'b10 || rd !== 16'h1234 || e !== 1'b1) begin failures++; $display("FAIL read_resp: done=%b rdata=%h err=%b want 10 1234 1", d, rd, e); end
    @(negedge clk); #1;
    checks++; if (done !== 2'b00 || rdata !== 16'h1234 || err !== 1'b1) begin failures++; $display("FAIL read_hold: done=%b rdata=%h err=%b want 00 1234 1", done, rdata, err); end
  endtask

  task automatic test_busy_stall();
    @(negedge clk);
    req = 2'b01; m_busy = 1'b1; wdata0 = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (m_start !== 1'b0 || gnt !== 2'b01) begin failures++; $display("FAIL stall_%0d: start=%b gnt=%b want 0 01", i, m_start, gnt); end
    end
    m_busy = 1'b0; #1;
    checks++; if (m_start !== 1'b1 || m_wdata !== 16'h5555) begin failures++; $display("FAIL stall_release: start=%b wdata=%h want 1 5555", m_start, m_wdata); end
    @(negedge clk);
    m_done = 1'b1; m_rdata = 16'h0042;
    @(negedge clk);
    m_done = 1'b0; req = 2'b00; #1;
    checks++; if (done !== 2'b01 || rdata !== 16'h0042) begin failures++; $display("FAIL stall_done: done=%b rdata=%h want 01 0042", done, rdata); end
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    req = 2'b10; rw1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req = 2'b11;
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    m_done = 1'b1; m_rdata = 16'h0777;
    @(negedge clk);
    m_done = 1'b0; req = 2'b00; #1;
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL withdraw_done: got %b want 10", done); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (gnt !== 2'b00 || m_start !== 1'b0) begin failures++; $display("FAIL withdraw_idle%0d: gnt=%b start=%b want 00 0", i, gnt, m_start); end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int j;
    @(negedge clk);
    req = 2'b01;
    @(negedge clk); #1;
    req = 2'b00;
    j = 0;
    while (j < 40) begin
      @(negedge clk); #1;
      if (m_abort) break;
      j++;
    end
    checks++; if (m_abort !== 1'b1 || j != TO) begin failures++; $display("FAIL timeout_abort: abort=%b at wait cycle %0d, want 1 at %0d", m_abort, j, TO); end
    @(negedge clk); #1;
    checks++; if (done !== 2'b01 || err !== 1'b1 || rdata !== '0 || m_abort !== 1'b0) begin failures++; $display("FAIL timeout_resp: done=%b err=%b rdata=%h abort=%b want 01 1 0000 0", done, err, rdata, m_abort); end
    @(negedge clk);
  endtask
`endif

  task automatic test_mid_reset();
    @(negedge clk);
    req = 2'b01; addr0 = 7'h50;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (gnt !== 2'b01 || m_addr !== 7'h50) begin failures++; $display("FAIL midrst_pre: gnt=%b addr=%h want 01 50", gnt, m_addr); end
    reset = 1'b1; #1;
    checks++; if (gnt !== 2'b00 || m_start !== 1'b0 || m_addr !== '0) begin failures++; $display("FAIL midrst_now: gnt=%b start=%b addr=%h want 00 0 00", gnt, m_start, m_addr); end
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (gnt !== 2'b00 || m_start !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL midrst_after: gnt=%b start=%b done=%b want 00 0 00", gnt, m_start, done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_read_return();
    test_busy_stall();
    test_withdraw();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench ran past 200000 time units");
    $fatal(1);
  end
endmodule
